// File: rtl/adc_scan_fsm.sv
// adc_scan_fsm: multi-channel SPI ADC scanner with pipelined addressing and a valid/ready result port
module adc_scan_fsm #(
    parameter int DIV_W      = 16,
    parameter int NUM_CH     = 8,
    parameter int CH_W       = 3,
    parameter int FRAME_BITS = 16,
    parameter int ADDR_POS   = 2,
    parameter int DATA_W     = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  clk_scaler,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              continuous,
    input  logic              start,
    output logic              busy,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [CH_W-1:0]   res_ch,
    output logic              irq,
    output logic              overrun
);
    localparam int TW = $clog2(2 * FRAME_BITS);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
    state_t state, state_nx;

    logic [DIV_W-1:0]  div, scaler_q;
    logic [NUM_CH-1:0] mask_q;
    logic [TW-1:0]     tcnt;
    logic [CH_W-1:0]   cur, dch, nxt_ch;
    logic [DATA_W-1:0] shreg;
    logic prime, fin, ld, has_nxt, mosi_bit;
    logic tick, accept, last_tick, frame_end, restart;

    function automatic logic [CH_W-1:0] first_of(input logic [NUM_CH-1:0] m);
        first_of = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i]) first_of = CH_W'(i);
    endfunction

    assign busy      = state != IDLE;
    assign tick      = busy && div == scaler_q;
    assign accept    = state == IDLE && start && |ch_mask;
    assign last_tick = state == SHIFT && tick && tcnt == TW'(2 * FRAME_BITS - 1);
    assign frame_end = state == HOLD && tick && tcnt == TW'(1);
    assign restart   = frame_end && fin && continuous && |ch_mask;

    always_comb begin
        nxt_ch   = '0;
        has_nxt  = 1'b0;
        mosi_bit = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (mask_q[i] && CH_W'(i) > cur && !has_nxt) begin
                nxt_ch  = CH_W'(i);
                has_nxt = 1'b1;
            end
        for (int i = 0; i < CH_W; i++)
            if (32'(tcnt[TW-1:1]) == ADDR_POS + i) mosi_bit = cur[CH_W-1-i];
        state_nx = accept                  ? SETUP :
                   (state == SETUP && tick) ? SHIFT :
                   last_tick               ? HOLD  :
                   frame_end               ? ((fin && !restart) ? IDLE : SETUP) : state;
    end

    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            div       <= '0;
            scaler_q  <= '0;
            mask_q    <= '0;
            tcnt      <= '0;
            cur       <= '0;
            dch       <= '0;
            shreg     <= '0;
            prime     <= 1'b0;
            fin       <= 1'b0;
            ld        <= 1'b0;
            sclk      <= 1'b1;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_ch    <= '0;
            irq       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            div <= (!busy || tick) ? '0 : div + DIV_W'(1);
            if (accept || restart) begin
                mask_q   <= ch_mask;
                scaler_q <= clk_scaler;
                cur      <= first_of(ch_mask);
                prime    <= 1'b1;
                fin      <= 1'b0;
            end else if (frame_end) begin
                dch   <= cur;
                prime <= 1'b0;
                cur   <= has_nxt ? nxt_ch : first_of(mask_q);
                fin   <= !has_nxt;
            end
            if (tick) begin
                tcnt <= (state == SETUP || last_tick) ? '0 : tcnt + TW'(1);
                if (state == SETUP) cs_n <= 1'b0;
                if (state == HOLD) cs_n <= 1'b1;
                if (state == SHIFT) sclk <= tcnt[0];
                if (state == SHIFT && !tcnt[0]) mosi <= mosi_bit;
                if (state == SHIFT && tcnt[0]) shreg <= {shreg[DATA_W-2:0], miso};
            end
            // the result is taken one cycle after the final rising-edge sample
            ld        <= last_tick && !prime;
            res_valid <= ld || (res_valid && !res_ready);
            irq       <= ld && fin;
            overrun   <= ld && res_valid && !res_ready;
            if (ld) begin
                res_data <= shreg;
                res_ch   <= dch;
            end
        end
    end
endmodule

// File: tb/tb_adc_scan_fsm.sv
// tb_adc_scan_fsm: directed vector bench for adc_scan_fsm with a behavioural ADC model
module tb_adc_scan_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] clk_scaler = '0;
    logic [7:0]  ch_mask = '0;
    logic        continuous = 1'b0;
    logic        start = 1'b0;
    logic        busy, sclk, cs_n, mosi, res_valid, irq, overrun;
    logic        miso = 1'b0;
    logic        res_ready = 1'b1;
    logic [11:0] res_data;
    logic [2:0]  res_ch;

    int n_cmp = 0;
    int n_err = 0;

    adc_scan_fsm dut (
        .clk(clk), .rst(rst), .clk_scaler(clk_scaler), .ch_mask(ch_mask),
        .continuous(continuous), .start(start), .busy(busy), .sclk(sclk),
        .cs_n(cs_n), .mosi(mosi), .miso(miso), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_ch(res_ch),
        .irq(irq), .overrun(overrun)
    );

    always #5 clk = ~clk;

    logic [11:0] chdata [8];
    int          fbit = 0;
    logic [2:0]  addr_sh = '0;
    logic [2:0]  conv_ch = '0;
    logic [2:0]  addr_q[$];

    // ADC model: address in one frame selects the conversion returned in the next
    always @(negedge cs_n) begin
        fbit    = 0;
        addr_sh = '0;
    end
    always @(negedge sclk) if (!cs_n) miso = (fbit >= 4) ? chdata[conv_ch][15-fbit] : 1'b0;
    always @(posedge sclk) if (!cs_n) begin
        if (fbit >= 2 && fbit <= 4) addr_sh = {addr_sh[1:0], mosi};
        fbit++;
    end
    always @(posedge cs_n) begin
        addr_q.push_back(addr_sh);
        conv_ch = addr_sh;
    end

    int          lo_cnt = 0;
    int          lo_q[$];
    logic [2:0]  ch_q[$];
    logic [11:0] dat_q[$];
    int          irq_cnt = 0;
    int          ov_cnt = 0;
    logic [2:0]  irq_ch = '0;

    always @(negedge clk) begin
        if (cs_n === 1'b0) lo_cnt++;
        else if (lo_cnt != 0) begin
            lo_q.push_back(lo_cnt);
            lo_cnt = 0;
        end
        if (res_valid && res_ready) begin
            ch_q.push_back(res_ch);
            dat_q.push_back(res_data);
        end
        if (irq) begin
            irq_cnt++;
            irq_ch = res_ch;
        end
        if (overrun) ov_cnt++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [7:0] m, input logic [15:0] s, input logic cont);
        @(negedge clk);
        lo_q.delete();
        addr_q.delete();
        ch_q.delete();
        dat_q.delete();
        irq_cnt    = 0;
        ov_cnt     = 0;
        ch_mask    = m;
        clk_scaler = s;
        continuous = cont;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
        check(nm, busy, 0);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  mask;
        logic [15:0] scaler;
        int          frames;
        int          lo_clk;
        logic [2:0]  first_ch;
        logic [2:0]  last_ch;
    } vec_t;
    vec_t vecs[$];

    initial begin
        logic [2:0] el[$];
        chdata = '{12'hA5C, 12'h5A3, 12'h3C1, 12'h0F0, 12'h7E8, 12'h123, 12'hFFF, 12'h801};
        vecs.push_back('{8'h05, 16'd0, 3, 33,  3'd0, 3'd2});
        vecs.push_back('{8'h05, 16'd3, 3, 132, 3'd0, 3'd2});
        vecs.push_back('{8'h80, 16'd1, 2, 66,  3'd7, 3'd7});
        vecs.push_back('{8'hFF, 16'd0, 9, 33,  3'd0, 3'd7});
        vecs.push_back('{8'h12, 16'd2, 3, 99,  3'd1, 3'd4});
        vecs.push_back('{8'h01, 16'd0, 2, 33,  3'd0, 3'd0});

        repeat (3) @(negedge clk);
        check("rst_sclk", sclk, 1);
        check("rst_cs_n", cs_n, 1);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_data", res_data, 0);
        check("rst_ch", res_ch, 0);
        check("rst_irq", irq, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;

        foreach (vecs[v]) begin
            launch(vecs[v].mask, vecs[v].scaler, 1'b0);
            wait_idle("scan_done");
            el.delete();
            for (int c = 0; c < 8; c++) if (vecs[v].mask[c]) el.push_back(3'(c));
            check("frames", lo_q.size(), vecs[v].frames);
            check("cs_low_clk", (lo_q.size() > 0) ? lo_q[0] : 0, vecs[v].lo_clk);
            check("n_results", ch_q.size(), vecs[v].frames - 1);
            for (int i = 0; i < vecs[v].frames; i++)
                check("addr", (i < addr_q.size()) ? 32'(addr_q[i]) : 32'hFF, 32'(el[i % el.size()]));
            for (int i = 0; i < ch_q.size() && i < el.size(); i++) begin
                check("res_ch", ch_q[i], el[i]);
                check("res_data", dat_q[i], chdata[el[i]]);
            end
            check("first_ch", (ch_q.size() > 0) ? 32'(ch_q[0]) : 32'hFF, vecs[v].first_ch);
            check("irq_count", irq_cnt, 1);
            check("irq_ch", irq_ch, vecs[v].last_ch);
            check("no_overrun", ov_cnt, 0);
        end

        res_ready = 1'b0;
        launch(8'h03, 16'd0, 1'b0);
        wait_idle("ovr_done");
        check("ovr_count", ov_cnt, 1);
        check("ovr_valid", res_valid, 1);
        check("ovr_ch", res_ch, 1);
        check("ovr_data", res_data, chdata[1]);
        check("ovr_irq", irq_cnt, 1);
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_cleared", res_valid, 0);

        launch(8'h80, 16'd0, 1'b1);
        for (int i = 0; i < 3000 && irq_cnt < 3; i++) @(negedge clk);
        check("cont_irqs", irq_cnt >= 3, 1);
        continuous = 1'b0;
        wait_idle("cont_stop");
        check("cont_frames", lo_q.size(), 2 * irq_cnt);
        check("cont_results", ch_q.size(), irq_cnt);
        foreach (ch_q[i]) begin
            check("cont_ch", ch_q[i], 7);
            check("cont_data", dat_q[i], chdata[7]);
        end

        launch(8'h00, 16'd0, 1'b0);
        repeat (5) @(negedge clk);
        check("mask0_busy", busy, 0);
        check("mask0_cs_n", cs_n, 1);

        launch(8'h01, 16'd0, 1'b0);
        repeat (20) @(negedge clk);
        ch_mask = 8'hFF;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("busy_start_done");
        check("busy_start_frames", lo_q.size(), 2);
        check("busy_start_results", ch_q.size(), 1);
        check("busy_start_ch", (ch_q.size() > 0) ? 32'(ch_q[0]) : 32'hFF, 0);

        launch(8'h05, 16'd3, 1'b0);
        for (int i = 0; i < 200 && sclk; i++) @(negedge clk);
        check("in_shift", sclk, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cs_n", cs_n, 1);
        check("midrst_sclk", sclk, 1);
        check("midrst_busy", busy, 0);
        check("midrst_valid", res_valid, 0);
        rst = 1'b0;
        launch(8'h05, 16'd0, 1'b0);
        wait_idle("after_rst_done");
        check("after_rst_results", ch_q.size(), 2);
        check("after_rst_data", (dat_q.size() > 1) ? 32'(dat_q[1]) : 32'hFFFF, chdata[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
